// File: rtl/nt_node_pkg.sv
// rtl/nt_node_pkg.sv - shared FSM state and count-mode encodings for the node activity monitor
package nt_node_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_LEVEL  = 1'b1
    } mode_t;

endpackage

// File: rtl/nt_node_sat_cnt.sv
// rtl/nt_node_sat_cnt.sv - per-channel event select and saturating counter
module nt_node_sat_cnt
    import nt_node_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          mode,
    input  logic          node,
    input  logic          node_q,
    output logic [CW-1:0] cnt
);

    logic evt;

    always_comb begin
        evt = (mode == MODE_LEVEL) ? node : (node ^ node_q);
    end

    // Holds at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && evt && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nt_node_activity_monitor.sv
// rtl/nt_node_activity_monitor.sv - windowed per-node toggle/level activity counter with rarity flags
module nt_node_activity_monitor
    import nt_node_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int WW  = 16
) (
    input  logic               I1470,
    input  logic               I1477,
    input  logic [NCH-1:0]     node_i,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [WW-1:0]      win_len_i,
    input  logic [CW-1:0]      thresh_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [NCH*CW-1:0]  count_o,
    output logic [NCH-1:0]     rare_o,
    output logic               any_rare_o
);

    state_t              state;
    state_t              state_nxt;
    logic [NCH-1:0]      node_q;
    mode_t               mode_q;
    logic [CW-1:0]       thresh_q;
    logic [WW-1:0]       rem;
    logic                start_acc;
    logic                cnt_en;
    logic [NCH*CW-1:0]   work;
    logic [NCH*CW-1:0]   res_q;
    logic [NCH-1:0]      rare_live;
    logic [NCH-1:0]      rare_q;
    logic [NCH-1:0]      rare_sel;

    always_comb begin
        start_acc = (state == ST_IDLE) && start_i;
        cnt_en    = (state == ST_COUNT);
    end

    always_ff @(posedge I1470) begin
        if (I1477) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = (win_len_i == '0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (rem == WW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Window parameters are captured only when a start is accepted.
    always_ff @(posedge I1470) begin
        if (I1477) begin
            node_q   <= '0;
            mode_q   <= MODE_TOGGLE;
            thresh_q <= '0;
            rem      <= '0;
            res_q    <= '0;
            rare_q   <= '0;
        end else begin
            node_q <= node_i;
            if (start_acc) begin
                mode_q   <= mode_t'(mode_i);
                thresh_q <= thresh_i;
                rem      <= win_len_i;
            end else if (state == ST_COUNT) begin
                rem <= rem - WW'(1);
            end
            if (state == ST_DONE) begin
                res_q  <= work;
                rare_q <= rare_live;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        nt_node_sat_cnt #(
            .CW (CW)
        ) u_cnt (
            .clk    (I1470),
            .rst    (I1477),
            .clr    (start_acc),
            .en     (cnt_en),
            .mode   (mode_q),
            .node   (node_i[g]),
            .node_q (node_q[g]),
            .cnt    (work[g*CW +: CW])
        );

        always_comb begin
            rare_live[g] = (work[g*CW +: CW] < thresh_q);
        end
    end

    // The DONE cycle presents the fresh result directly so done_o and the data line up.
    always_comb begin
        busy_o     = (state == ST_COUNT);
        done_o     = (state == ST_DONE);
        count_o    = (state == ST_DONE) ? work : res_q;
        rare_sel   = (state == ST_DONE) ? rare_live : rare_q;
        rare_o     = rare_sel;
        any_rare_o = |rare_sel;
    end

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// tb/tb_nt_node_activity_monitor.sv - directed vector bench for nt_node_activity_monitor
module tb_nt_node_activity_monitor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   node = 8'h00;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [15:0]  win = 16'd0;
    logic [15:0]  th = 16'd0;

    logic         busy, done, any_rare;
    logic [127:0] cnt;
    logic [7:0]   rare;
    logic         s_busy, s_done, s_any;
    logic [31:0]  s_cnt;
    logic [7:0]   s_rare;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    nt_node_activity_monitor #(.NCH(8), .CW(16), .WW(16)) dut (
        .I1470(clk), .I1477(rst), .node_i(node), .start_i(start), .mode_i(mode),
        .win_len_i(win), .thresh_i(th), .busy_o(busy), .done_o(done),
        .count_o(cnt), .rare_o(rare), .any_rare_o(any_rare)
    );

    nt_node_activity_monitor #(.NCH(8), .CW(4), .WW(16)) dut_sat (
        .I1470(clk), .I1477(rst), .node_i(node), .start_i(start), .mode_i(mode),
        .win_len_i(win), .thresh_i(th[3:0]), .busy_o(s_busy), .done_o(s_done),
        .count_o(s_cnt), .rare_o(s_rare), .any_rare_o(s_any)
    );

    typedef struct {
        logic [7:0]   tog;
        logic [7:0]   lvl;
        int           hi;
        logic         mode;
        int           win;
        logic [15:0]  th;
        logic [127:0] exp_cnt;
        logic [7:0]   exp_rare;
        logic [3:0]   exp_sat0;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [127:0] cnt_at(input int ch, input int v);
        logic [127:0] r;
        r = 128'(v);
        return r << (ch * 16);
    endfunction

    function automatic vec_t mk(input logic [7:0] tog, input logic [7:0] lvl, input int hi,
                                input logic md, input int w, input logic [15:0] t,
                                input logic [127:0] ec, input logic [7:0] er, input logic [3:0] es);
        vec_t v;
        v.tog = tog; v.lvl = lvl; v.hi = hi; v.mode = md; v.win = w; v.th = t;
        v.exp_cnt = ec; v.exp_rare = er; v.exp_sat0 = es;
        return v;
    endfunction

    function automatic logic [7:0] node_for(input vec_t v, input int k);
        logic [7:0] r;
        logic       ph;
        ph = k[0];
        r = v.tog & {8{ph}};
        if (k >= 1 && k <= v.hi) r = r | v.lvl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t         v;
        int           done_k;
        int           ndone;
        logic         busy1, hold_done;
        logic [127:0] c_cnt, h_cnt;
        logic [7:0]   c_rare;
        logic         c_any;
        logic [3:0]   c_sat;
        v = vecs[idx];
        done_k = -1; ndone = 0; busy1 = 1'b0; hold_done = 1'b1;
        c_cnt = '1; h_cnt = '1; c_rare = 8'hxx; c_any = 1'bx; c_sat = 4'hx;
        @(posedge clk); #1;
        start = 1'b1; mode = v.mode; win = 16'(v.win); th = v.th; node = node_for(v, 0);
        for (int k = 1; k <= v.win + 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            node = node_for(v, k);
            if (k == 1) busy1 = busy;
            if (done) ndone++;
            if (done && done_k < 0) begin
                done_k = k; c_cnt = cnt; c_rare = rare; c_any = any_rare; c_sat = s_cnt[3:0];
            end
            if (done_k > 0 && k == done_k + 1) begin
                hold_done = done; h_cnt = cnt;
            end
        end
        node = 8'h00;
        chk($sformatf("v%0d latency", idx), 128'(done_k), 128'(v.win + 1));
        chk($sformatf("v%0d pulses", idx), 128'(ndone), 128'd1);
        chk($sformatf("v%0d busy_first", idx), 128'(busy1), 128'(v.win > 0));
        chk($sformatf("v%0d count", idx), c_cnt, v.exp_cnt);
        chk($sformatf("v%0d rare", idx), 128'(c_rare), 128'(v.exp_rare));
        chk($sformatf("v%0d any_rare", idx), 128'(c_any), 128'(v.exp_rare != 8'h00));
        chk($sformatf("v%0d sat_count0", idx), 128'(c_sat), 128'(v.exp_sat0));
        chk($sformatf("v%0d done_one_cycle", idx), 128'(hold_done), 128'd0);
        chk($sformatf("v%0d count_held", idx), h_cnt, v.exp_cnt);
    endtask

    initial begin
        int           ndone;
        int           done_k;
        logic [127:0] c_cnt;

        vecs[0] = mk(8'h01, 8'h00, 0, 1'b0, 10, 16'd3, cnt_at(0, 10), 8'hFE, 4'd10);
        vecs[1] = mk(8'h00, 8'h08, 4, 1'b1, 10, 16'd5, cnt_at(3, 4), 8'hFF, 4'd0);
        vecs[2] = mk(8'h01, 8'h00, 0, 1'b0, 40, 16'd0, cnt_at(0, 40), 8'h00, 4'd15);
        vecs[3] = mk(8'h00, 8'h00, 0, 1'b0, 0, 16'd0, 128'd0, 8'h00, 4'd0);
        vecs[4] = mk(8'h00, 8'h00, 0, 1'b0, 0, 16'd1, 128'd0, 8'hFF, 4'd0);
        vecs[5] = mk(8'h00, 8'h08, 4, 1'b0, 10, 16'd2, cnt_at(3, 2), 8'hF7, 4'd0);
        vecs[6] = mk(8'h81, 8'h00, 0, 1'b1, 10, 16'd6, cnt_at(0, 5) | cnt_at(7, 5), 8'hFF, 4'd5);
        vecs[7] = mk(8'h01, 8'h00, 0, 1'b0, 1, 16'd1, cnt_at(0, 1), 8'hFE, 4'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset count", cnt, 128'd0);
        chk("reset rare", 128'(rare), 128'd0);
        chk("reset any_rare", 128'(any_rare), 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Reset on cycle 5 of a 10-cycle window: no pulse, results cleared.
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; win = 16'd10; th = 16'd3; node = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0; node = {7'd0, k[0]};
            if (k == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort count", cnt, 128'd0);
        chk("abort rare", 128'(rare), 128'd0);
        chk("abort any_rare", 128'(any_rare), 128'd0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            node = {7'd0, k[0]};
            if (done) ndone++;
        end
        node = 8'h00;
        chk("abort no_done", 128'(ndone), 128'd0);
        run_vec(0);

        // Second start mid-window must be ignored.
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; win = 16'd10; th = 16'd3; node = 8'h00;
        ndone = 0; done_k = -1; c_cnt = '1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start = (k == 4);
            if (k == 4) win = 16'd2;
            node = {7'd0, k[0]};
            if (done) begin
                ndone++;
                if (done_k < 0) begin done_k = k; c_cnt = cnt; end
            end
        end
        start = 1'b0; node = 8'h00;
        chk("busy_start pulses", 128'(ndone), 128'd1);
        chk("busy_start latency", 128'(done_k), 128'd11);
        chk("busy_start count", c_cnt, cnt_at(0, 10));

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/nt_node_activity_monitor.md
NT_NODE_ACTIVITY_MONITOR -- requirements
Module: nt_node_activity_monitor

Interface
REQ-001 SHALL have parameter NCH, default 8: number of monitored subcircuit nodes.
REQ-002 SHALL have parameter CW, default 16: per-channel counter width.
REQ-003 SHALL have parameter WW, default 16: window-length width.
REQ-004 SHALL have port I1470  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port I1477  input  1: reset; synchronous, active-high.
REQ-006 SHALL have port node_i  input  NCH: observed netlist nodes, already synchronous to I1470.
REQ-007 SHALL have port start_i  input  1: request a measurement window.
REQ-008 SHALL have port mode_i  input  1: 0 = count toggles, 1 = count cycles at logic 1; sampled on the start cycle.
REQ-009 SHALL have port win_len_i  input  WW: window length in cycles; sampled on the start cycle.
REQ-010 SHALL have port thresh_i  input  CW: rarity threshold; sampled on the start cycle.
REQ-011 SHALL have port busy_o  output  1: window in progress.
REQ-012 SHALL have port done_o  output  1: one-cycle pulse when results update.
REQ-013 SHALL have port count_o  output  NCH*CW: per-channel result, channel i at bits [i*CW +: CW].
REQ-014 SHALL have port rare_o  output  NCH: channel i result < latched threshold.
REQ-015 SHALL have port any_rare_o  output  1: OR-reduction of rare_o.

Function
REQ-016 SHALL implement FSM IDLE, COUNT, DONE; IDLE->COUNT on start_i=1 with win_len_i>0; IDLE->DONE on start_i=1 with win_len_i=0; COUNT->DONE on the last window cycle; DONE->IDLE unconditionally.
REQ-017 SHALL register node_i into node_q every cycle in all states; toggle event for channel i = node_i[i] XOR node_q[i].
REQ-018 SHALL, in COUNT, increment channel i counter by 1 per event (mode 0: toggle; mode 1: node_i[i]=1); working counters clear on the start cycle.
REQ-019 SHALL saturate each counter at 2^CW-1; no wrap-around.
REQ-020 SHALL count exactly win_len cycles: the first COUNT cycle is the cycle after start, and the remaining-cycle counter counts down to 1.
REQ-021 SHALL ignore start_i while busy_o=1 or in DONE.
REQ-022 SHALL, in DONE, copy working counters to count_o, compute rare_o and any_rare_o, and assert done_o for that cycle only.
REQ-023 SHALL hold count_o, rare_o and any_rare_o stable between DONE cycles.
REQ-024 SHALL produce an all-zero result with rare_o[i]=1 iff thresh>0 for win_len=0.
REQ-025 SHALL assert busy_o exactly while the FSM is in COUNT.
REQ-026 SHALL treat events in the DONE cycle as not counted.

Reset
REQ-027 SHALL, with I1477=1 at a clock edge, force state IDLE, busy_o=0, done_o=0, count_o=0, rare_o=0, any_rare_o=0, node_q=0, and clear all counters and latched mode/threshold/length.
REQ-028 SHALL, on reset during COUNT, abort the window without a done_o pulse or result update.
REQ-029 SHALL give reset priority over start_i in the same cycle.

Structure
REQ-030 SHALL take FSM state enum and mode encodings from shared package nt_node_pkg.
REQ-031 SHALL implement per-channel saturating counter plus event select as sub-module nt_node_sat_cnt, instantiated NCH times by generate.
REQ-032 SHALL contain no latches, no async reset, and no derived clocks.

Verification
REQ-033 SHALL verify toggle mode: NCH=8; node_i[0] toggles every cycle, others constant; start with win=10, thresh=3, mode=0 -> done_o 11 cycles after start; count0=10, others 0; rare_o=8'hFE; any_rare_o=1.
REQ-034 SHALL verify level mode: node_i[3]=1 for 4 of 10 window cycles; mode=1, thresh=5 -> count3=4, rare_o[3]=1.
REQ-035 SHALL verify saturation: CW=4; toggle node_i[0] for win=40 -> count0=15 with no wrap.
REQ-036 SHALL verify zero window: win=0, thresh=0 -> done_o on the cycle after start, counts 0, rare_o=0.
REQ-037 SHALL verify abort: reset asserted on cycle 5 of a win=10 window -> no done_o; outputs 0; a new start afterwards completes normally.
REQ-038 SHALL verify start-during-busy: start_i pulsed mid-window -> ignored; only one done_o pulse.
